// File: rtl/cmp_seq.sv
// Multi-cycle magnitude comparator: walks two WORDS x 16-bit operands MSW first,
// chaining a big/equal/small flag triple from word to word.
module cmp_seq #(
  parameter int WORDS      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sgn,
  input  logic [16*WORDS-1:0]          a,
  input  logic [16*WORDS-1:0]          b,
  output logic                         busy,
  output logic                         done,
  output logic                         fo_big,
  output logic                         fo_equal,
  output logic                         fo_small,
  output logic [$clog2(WORDS+1)-1:0]   words_used
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW = $clog2(WORDS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_reg;
  logic [16*WORDS-1:0]    a_reg;
  logic [16*WORDS-1:0]    b_reg;
  logic                   sgn_reg;
  logic [IW-1:0]          idx_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   big_reg;
  logic                   eq_reg;
  logic                   small_reg;

  logic [15:0]            a_words [WORDS];
  logic [15:0]            b_words [WORDS];
  logic [15:0]            word_a;
  logic [15:0]            word_b;
  logic                   big_next;
  logic                   eq_next;
  logic                   small_next;
  logic [CW-1:0]          cnt_next;
  logic                   finish;

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_slice
    assign a_words[gi] = a_reg[16*gi +: 16];
    assign b_words[gi] = b_reg[16*gi +: 16];
  end

  always_comb begin
    word_a = a_words[idx_reg];
    word_b = b_words[idx_reg];
    // Flipping the sign bit of the top word turns an unsigned compare into a signed one.
    if (sgn_reg && (idx_reg == LAST_IDX)) begin
      word_a[15] = ~word_a[15];
      word_b[15] = ~word_b[15];
    end
    if (eq_reg) begin
      big_next   = (word_a > word_b);
      eq_next    = (word_a == word_b);
      small_next = (word_a < word_b);
    end else begin
      big_next   = big_reg;
      eq_next    = eq_reg;
      small_next = small_reg;
    end
    cnt_next = cnt_reg + CNT_ONE;
    finish   = (idx_reg == '0) || ((EARLY_EXIT != 0) && !eq_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      sgn_reg    <= 1'b0;
      idx_reg    <= '0;
      cnt_reg    <= '0;
      big_reg    <= 1'b0;
      eq_reg     <= 1'b0;
      small_reg  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fo_big     <= 1'b0;
      fo_equal   <= 1'b0;
      fo_small   <= 1'b0;
      words_used <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            sgn_reg   <= sgn;
            idx_reg   <= LAST_IDX;
            cnt_reg   <= '0;
            big_reg   <= 1'b0;
            eq_reg    <= 1'b1;
            small_reg <= 1'b0;
            fo_big    <= 1'b0;
            fo_equal  <= 1'b0;
            fo_small  <= 1'b0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          big_reg   <= big_next;
          eq_reg    <= eq_next;
          small_reg <= small_next;
          cnt_reg   <= cnt_next;
          if (finish) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            fo_big     <= big_next;
            fo_equal   <= eq_next;
            fo_small   <= small_next;
            words_used <= cnt_next;
            state_reg  <= DONE;
          end else begin
            idx_reg <= idx_reg - IDX_ONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq.sv
// Scoreboard bench for cmp_seq: one early-exit instance and one fixed-latency instance,
// expected results queued at start and checked by monitors on each done pulse.
module tb_cmp_seq;

  typedef struct packed {
    logic [2:0]  fo;
    logic [2:0]  wu;
    logic [31:0] dcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic        sgn0, sgn1;
  logic [63:0] a0, b0, a1, b1;
  logic        busy0, done0, big0, eq0, small0;
  logic        busy1, done1, big1, eq1, small1;
  logic [2:0]  wu0, wu1;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cmp_seq #(.WORDS(4), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst(rst), .start(start0), .sgn(sgn0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .fo_big(big0), .fo_equal(eq0), .fo_small(small0),
    .words_used(wu0)
  );

  cmp_seq #(.WORDS(4), .EARLY_EXIT(0)) dut_fix (
    .clk(clk), .rst(rst), .start(start1), .sgn(sgn1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .fo_big(big1), .fo_equal(eq1), .fo_small(small1),
    .words_used(wu1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic on_done(input int d, input logic [2:0] fo, input logic [2:0] wu);
    exp_t e;
    if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_done dut%0d: got done=1 expected none (cycle %0d)", d, cyc);
    end else begin
      if (d == 0) e = sb0.pop_front();
      else        e = sb1.pop_front();
      chk($sformatf("dut%0d fo{big,eq,small}", d), {29'd0, fo}, {29'd0, e.fo});
      chk($sformatf("dut%0d words_used", d), {29'd0, wu}, {29'd0, e.wu});
      chk($sformatf("dut%0d done_cycle", d), cyc, e.dcyc);
    end
  endtask

  always @(negedge clk) if (done0 === 1'b1) on_done(0, {big0, eq0, small0}, wu0);
  always @(negedge clk) if (done1 === 1'b1) on_done(1, {big1, eq1, small1}, wu1);

  // Called at a negedge; the start is sampled on the following posedge.
  task automatic launch(input int d, input logic [63:0] av, input logic [63:0] bv,
                        input logic s, input logic [2:0] fo, input logic [2:0] wu,
                        input int k, input bit push);
    exp_t e;
    e.fo = fo;
    e.wu = wu;
    e.dcyc = cyc + 1 + k;
    if (d == 0) begin
      start0 = 1'b1; a0 = av; b0 = bv; sgn0 = s;
      if (push) sb0.push_back(e);
    end else begin
      start1 = 1'b1; a1 = av; b1 = bv; sgn1 = s;
      if (push) sb1.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && (sb0.size() != 0 || sb1.size() != 0); i++) @(negedge clk);
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done, expected %0d pending results", sb0.size() + sb1.size());
      sb0.delete();
      sb1.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_one(input int d, input logic [63:0] av, input logic [63:0] bv,
                         input logic s, input logic [2:0] fo, input logic [2:0] wu, input int k);
    launch(d, av, bv, s, fo, wu, k, 1'b1);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    wait_idle();
  endtask

  task automatic chk_quiet(input string name);
    chk({name, " busy"}, {31'd0, busy0}, 32'd0);
    chk({name, " done"}, {31'd0, done0}, 32'd0);
    chk({name, " fo"}, {29'd0, big0, eq0, small0}, 32'd0);
    chk({name, " words_used"}, {29'd0, wu0}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b1; start1 = 1'b0;
    sgn0 = 1'b0; sgn1 = 1'b0;
    a0 = 64'h1; b0 = 64'h2; a1 = '0; b1 = '0;
    @(negedge clk); @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0; start0 = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_quiet("idle");

    // Early-exit instance: directed vectors {big,eq,small}
    run_one(0, 64'h0002_0000_0000_0000, 64'h0001_FFFF_FFFF_FFFF, 1'b0, 3'b100, 3'd1, 1);
    run_one(0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 3'b010, 3'd4, 4);
    run_one(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1, 3'b001, 3'd1, 1);
    run_one(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 3'b100, 3'd1, 1);
    run_one(0, 64'h0000_0000_0005_0000, 64'h0000_0000_0004_FFFF, 1'b0, 3'b100, 3'd3, 3);
    run_one(0, 64'hFFFF_FFFF_0000_0001, 64'hFFFF_FFFF_0000_0002, 1'b1, 3'b001, 3'd4, 4);
    run_one(0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 3'b001, 3'd1, 1);
    run_one(0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b100, 3'd1, 1);

    // start pulsed mid-RUN with other operands must be ignored
    launch(0, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0002, 1'b0, 3'b100, 3'd4, 4, 1'b1);
    @(negedge clk);
    a0 = 64'h0; b0 = 64'hFFFF_FFFF_FFFF_FFFF; sgn0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle();

    // start held through DONE: next compare begins with no idle gap
    launch(0, 64'h0002_0000_0000_0000, 64'h0001_FFFF_FFFF_FFFF, 1'b0, 3'b100, 3'd1, 1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    launch(0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 3'b010, 3'd4, 4, 1'b1);
    @(negedge clk);
    start0 = 1'b0;
    chk("b2b busy", {31'd0, busy0}, 32'd1);
    chk("b2b fo cleared", {29'd0, big0, eq0, small0}, 32'd0);
    wait_idle();

    // abort on the second RUN cycle
    launch(0, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 1'b0, 3'b010, 3'd4, 4, 1'b0);
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_quiet("abort");
    repeat (6) @(negedge clk);
    run_one(0, 64'h0000_0000_0005_0000, 64'h0000_0000_0004_FFFF, 1'b0, 3'b100, 3'd3, 3);

    // Fixed-latency instance: always four words, result decided by first differing word
    run_one(1, 64'h0002_0000_0000_0000, 64'h0001_FFFF_FFFF_FFFF, 1'b0, 3'b100, 3'd4, 4);
    run_one(1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 3'b010, 3'd4, 4);
    run_one(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1, 3'b001, 3'd4, 4);
    run_one(1, 64'h0000_0000_0004_FFFF, 64'h0000_0000_0005_0000, 1'b0, 3'b001, 3'd4, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_seq.md
Name: cmp_seq

Overview:
Multi-cycle magnitude-compare sequencer for operands wider than one 16-bit compare slice. It latches two WORDS×16-bit operands on a start request and walks them one 16-bit word per cycle, most-significant word first. A running big/equal/small flag triple is chained from word to word, the same way the cascaded fi_*/fo_* comparator chain works. It sits between a requesting master (start/done handshake) and downstream logic that consumes the one-hot result flags.

Parameters:
WORDS, 4, number of 16-bit words per operand (≥1); operand width = 16*WORDS
EARLY_EXIT, 1, 1 = finish as soon as a word differs; 0 = always examine all WORDS words (fixed latency)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a compare; sampled only when accepted (see Behaviour)
sgn  input  1  1 = operands are two's-complement signed, 0 = unsigned; latched with start
a  input  16*WORDS  operand A, word 0 = bits [15:0]; latched with start
b  input  16*WORDS  operand B; latched with start
busy  output  1  high while a compare is in progress
done  output  1  one-cycle pulse: result flags valid and newly updated
fo_big  output  1  A > B
fo_equal  output  1  A == B
fo_small  output  1  A < B
words_used  output  clog2(WORDS+1)  number of words examined for the last result

Behaviour:
- Reset: all registers are cleared synchronously when rst=1. busy=0, done=0, fo_big=fo_equal=fo_small=0, words_used=0, state=IDLE. rst overrides start and aborts any compare in progress; no done pulse is produced for an aborted compare.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - start is accepted in IDLE or DONE (back-to-back compares are allowed) and ignored in RUN.
  - On acceptance: latch a, b and sgn; set idx=WORDS-1; set running flags to {big,eq,small}={0,1,0}; clear fo_* to 0; go to RUN.
- RUN, one word per cycle:
  - Compare word idx of A against word idx of B as 16-bit values.
  - If sgn=1 and idx=WORDS-1, invert bit 15 of both words before comparing, so the compare is signed.
  - Chaining: if the running eq=1, the new running flags are the word result. Otherwise the running flags hold (a higher word already decided).
  - Increment the examined-word counter.
  - Exit to DONE when idx==0, or when EARLY_EXIT=1 and the updated running eq=0. Otherwise decrement idx.
- DONE (exactly one cycle):
  - done=1 and busy=0.
  - fo_* take the final running flags; exactly one is 1.
  - words_used takes the counter value.
  - Next state is RUN if start=1, otherwise IDLE.
- Output hold: fo_* and words_used hold after DONE until the next accepted start, which clears fo_* to 0.
- busy: 1 exactly in RUN.
- Latency: start accepted in cycle T gives RUN in cycles T+1..T+k and the done pulse in cycle T+k+1.
  - k = WORDS when EARLY_EXIT=0.
  - k = 1 + (number of equal leading MSWs), capped at WORDS, when EARLY_EXIT=1.
- Boundary cases:
  - WORDS=1: k=1 always.
  - Fully equal operands: k=WORDS and fo_equal=1.
  - The operand inputs may change during RUN with no effect on the result.
  - If start is held high continuously, a new compare begins at every DONE.

Test Plan:
- Reset and idle: assert rst for 2 cycles with start=1 → busy=0, done=0, all fo_*=0, words_used=0. After release with start=0, outputs stay 0.
- Unsigned early exit (WORDS=4, EARLY_EXIT=1): a=0x0002_0000_0000_0000, b=0x0001_FFFF_FFFF_FFFF → done 2 cycles after start, fo_big=1, words_used=1.
- Equal operands: a=b=0x1234_5678_9ABC_DEF0 → done at T+5, fo_equal=1, words_used=4. Repeat with EARLY_EXIT=0 and a≠b in the MSW → done still at T+5, and the result is decided by the MSW.
- Signed compare (sgn=1): a=0xFFFF_FFFF_FFFF_FFFF (−1), b=0x0000_0000_0000_0001 → fo_small=1. The same operands with sgn=0 → fo_big=1.
- Handshake:
  - Pulse start again mid-RUN with different operands → ignored; the result reflects the first operands.
  - start high during DONE → busy=1 on the next cycle with no idle gap, and fo_* cleared.
- Abort: assert rst on the 2nd RUN cycle → next cycle busy=0, no done pulse, fo_*=0. A fresh start afterwards completes normally.
